// File: rtl/palu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : palu_pkg
//  Description : Shared definitions for pipelined_alu_display. Holds the ALU
//                operation encoding and the active-low seven-segment hex
//                pattern table ({a,b,c,d,e,f,g,dp}, bit 7 = a).
//  Revision    : 1.0 - initial release
// ============================================================================
package palu_pkg;

    // ALU operation select encoding
    typedef enum logic [2:0] {
        OP_SUB = 3'b000,
        OP_ADD = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_ASR = 3'b100,
        OP_ROL = 3'b101,
        OP_LT  = 3'b110,
        OP_EQ  = 3'b111
    } op_e;

    // Segment patterns, index 0 is the leftmost entry (digit "0")
    localparam logic [0:15][7:0] C_SEG_LUT = {
        8'h03, 8'h9F, 8'h25, 8'h0D,
        8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1,
        8'h63, 8'h85, 8'h61, 8'h71
    };

    // Segment pattern lookup for a single hex nibble
    function automatic logic [7:0] seg_pattern(input logic [3:0] nibble);
        return C_SEG_LUT[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg_hex_decode
//  Description : Combinational 4-bit hex nibble to active-low seven-segment
//                pattern decoder ({a,b,c,d,e,f,g,dp}, decimal point off).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decode (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);
    import palu_pkg::*;

    // Table lookup of the pattern for the requested nibble
    always_comb begin
        seg = seg_pattern(nibble);
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_alu_display.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_alu_display
//  Description : Single-stage valid/ready ALU with a registered result and a
//                multiplexed hex seven-segment display of the most recently
//                accepted result.
//                Build option: define PALU_SIGNED_CMP_EN to make the
//                less-than operation compare two's-complement signed values
//                (default build compares unsigned).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_alu_display #(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   rd,
    output logic [7:0]         seg,
    output logic [WIDTH/4-1:0] an
);
    import palu_pkg::*;

    localparam int DIGITS = WIDTH / 4;
    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] C_DIG_MAX = DIG_W'(DIGITS - 1);

    // Handshake / result state
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  rd_q, rd_d;
    logic [WIDTH-1:0]  disp_q, disp_d;
    // Display scan state
    logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic              accept;
    logic [WIDTH-1:0]  alu_res;
    logic              lt_bit;
    logic [3:0]        cur_nibble;
    logic [7:0]        cur_pattern;

    // Ready whenever the result register is empty or being drained this cycle
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
    end

    // ALU datapath; compare ops return the flag in bit 0
    always_comb begin
        alu_res = '0;
`ifdef PALU_SIGNED_CMP_EN
        lt_bit  = $signed(rs) < $signed(rt);
`else
        lt_bit  = rs < rt;
`endif
        case (op_e'(op))
            OP_SUB:  alu_res = rs - rt;
            OP_ADD:  alu_res = rs + rt;
            OP_OR:   alu_res = rs | rt;
            OP_AND:  alu_res = rs & rt;
            OP_ASR:  alu_res = {rt[WIDTH-1], rt[WIDTH-1:1]};
            OP_ROL:  alu_res = {rs[WIDTH-2:0], rs[WIDTH-1]};
            OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, lt_bit};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (rs == rt)};
            default: alu_res = '0;
        endcase
    end

    // Result register and display register next-state
    always_comb begin
        out_valid_d = out_valid_q;
        rd_d        = rd_q;
        disp_d      = disp_q;
        if (accept) begin
            out_valid_d = 1'b1;
            rd_d        = alu_res;
            disp_d      = alu_res;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Scan counter and digit index: digit advances once per SCAN_DIV cycles
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (scan_cnt_q == C_CNT_MAX) begin
            scan_cnt_d = '0;
            digit_d    = (digit_q == C_DIG_MAX) ? '0 : digit_q + 1'b1;
        end
    end

    // Select the nibble and one-hot active-low enable for the current digit
    always_comb begin
        cur_nibble = disp_q[3:0];
        an_d       = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_q == DIG_W'(i)) begin
                cur_nibble = disp_q[4*i +: 4];
                an_d[i]    = 1'b0;
            end
        end
    end

    seg_hex_decode u_seg_hex_decode (
        .nibble (cur_nibble),
        .seg    (cur_pattern)
    );

    // Segment output is registered alongside the digit enable
    always_comb begin
        seg_d = cur_pattern;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            disp_q      <= '0;
            scan_cnt_q  <= '0;
            digit_q     <= '0;
            an_q        <= '1;
            seg_q       <= 8'hFF;
        end else begin
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            disp_q      <= disp_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_alu_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_alu_display
//  Description : Self-checking bench for pipelined_alu_display (WIDTH=8,
//                SCAN_DIV=4) against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_alu_display;

    localparam int WIDTH    = 8;
    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] rs;
    logic [7:0] rt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] rd;
    logic [7:0] seg;
    logic [1:0] an;

    int checks = 0;
    int errors = 0;

    pipelined_alu_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    // Hex digit patterns written out from the display table
    function automatic logic [7:0] hex_seg(input int n);
        case (n)
            0: return 8'b00000011;  1: return 8'b10011111;
            2: return 8'b00100101;  3: return 8'b00001101;
            4: return 8'b10011001;  5: return 8'b01001001;
            6: return 8'b01000001;  7: return 8'b00011111;
            8: return 8'b00000001;  9: return 8'b00001001;
            10: return 8'b00010001; 11: return 8'b11000001;
            12: return 8'b01100011; 13: return 8'b10000101;
            14: return 8'b01100001; default: return 8'b01110001;
        endcase
    endfunction

    // Reference ALU using integer arithmetic on 0..255 values
    function automatic logic [7:0] ref_alu(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, sa, sb, r;
        ia = a;
        ib = b;
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        case (o)
            3'd0: r = (ia - ib + 256) % 256;
            3'd1: r = (ia + ib) % 256;
            3'd2: r = a | b;
            3'd3: r = a & b;
            3'd4: r = ib / 2 + ((ib >= 128) ? 128 : 0);
            3'd5: r = (ia * 2) % 256 + ia / 128;
`ifdef PALU_SIGNED_CMP_EN
            3'd6: r = (sa < sb) ? 1 : 0;
`else
            3'd6: r = (ia < ib) ? 1 : 0;
`endif
            default: r = (ia == ib) ? 1 : 0;
        endcase
        return r[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_dut();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; rs = 8'd0; rt = 8'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Reset with a pending result and a request on the input
    task automatic test_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd1; rs = 8'h12; rt = 8'h34;
        tick();
        in_valid = 1'b0;
        checks++;
        if (rd !== 8'h46 || out_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_load: rd=%h ov=%b required rd=46 ov=1", rd, out_valid);
        end
        rst_n = 1'b0; in_valid = 1'b1; op = 3'd2; rs = 8'hF0; rt = 8'h0F;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || rd !== 8'h00 || an !== 2'b11 || seg !== 8'hFF) begin
                errors++;
                $display("FAIL reset_state: ov=%b rd=%h an=%b seg=%b required ov=0 rd=00 an=11 seg=11111111",
                         out_valid, rd, an, seg);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if (an !== 2'b10 || seg !== 8'b00000011 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_release: an=%b seg=%b ov=%b required an=10 seg=00000011 ov=0", an, seg, out_valid);
        end
    endtask

    // One request, result checked the cycle after acceptance
    task automatic do_op(input string name, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] exp_v;
        exp_v = ref_alu(o, a, b);
        out_ready = 1'b1;
        in_valid = 1'b1; op = o; rs = a; rt = b;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready: in_ready=%b required 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (rd !== exp_v || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: op=%0d rs=%h rt=%h rd=%h ov=%b required rd=%h ov=1", name, o, a, b, rd, out_valid, exp_v);
        end
    endtask

    task automatic test_directed_ops();
        do_op("add_7f_01", 3'd1, 8'h7F, 8'h01);
        tick();
        checks++;
        if (out_valid !== 1'b0 || rd !== 8'h80) begin
            errors++; $display("FAIL drain: ov=%b rd=%h required ov=0 rd=80", out_valid, rd);
        end
        do_op("sub_03_05", 3'd0, 8'h03, 8'h05);
        do_op("asr_81",    3'd4, 8'h00, 8'h81);
        do_op("rol_81",    3'd5, 8'h81, 8'h00);
        do_op("add_wrap",  3'd1, 8'hFF, 8'h01);
        do_op("sub_wrap",  3'd0, 8'h00, 8'h01);
        do_op("lt_80_01",  3'd6, 8'h80, 8'h01);
        do_op("eq_5a",     3'd7, 8'h5A, 8'h5A);
        do_op("eq_ne",     3'd7, 8'h5A, 8'h5B);
        tick();
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 40; i++) begin
            do_op("rand_op", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    // Stream of requests with out_ready held high: no bubbles
    task automatic test_back_to_back();
        logic [2:0] o;
        logic [7:0] a, b, exp_v;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            o = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
            exp_v = ref_alu(o, a, b);
            in_valid = 1'b1; op = o; rs = a; rt = b;
            tick();
            checks++;
            if (rd !== exp_v || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b: op=%0d rs=%h rt=%h rd=%h ov=%b required rd=%h ov=1", o, a, b, rd, out_valid, exp_v);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    // Held result under backpressure, then simultaneous drain and accept
    task automatic test_backpressure();
        logic [7:0] nb;
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd1; rs = 8'h7F; rt = 8'h01;
        tick();
        nb = 8'($urandom);
        op = 3'd2; rs = 8'h0C; rt = nb;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready !== 1'b0 || rd !== 8'h80 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall: in_ready=%b rd=%h ov=%b required in_ready=0 rd=80 ov=1", in_ready, rd, out_valid);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (rd !== (8'h0C | nb) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL swap: rd=%h ov=%b required rd=%h ov=1", rd, out_valid, 8'h0C | nb);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || rd !== (8'h0C | nb)) begin
            errors++; $display("FAIL final_drain: ov=%b rd=%h required ov=0 rd=%h", out_valid, rd, 8'h0C | nb);
        end
    endtask

    // Display of 0x3A: digit 0 shows A, digit 1 shows 3, four cycles each
    task automatic test_display();
        logic [1:0] prev_an;
        int         d;
        bit         seen;
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd2; rs = 8'h3A; rt = 8'h00;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        prev_an = an;
        seen = 1'b0;
        for (int c = 0; c < 3 * SCAN_DIV && !seen; c++) begin
            tick();
            if (an !== prev_an) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL scan_timeout: an=%b stayed constant", an);
        end
        d = (an === 2'b10) ? 0 : 1;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < SCAN_DIV; c++) begin
                checks++;
                if (an !== ((d == 0) ? 2'b10 : 2'b01) || seg !== hex_seg((d == 0) ? 10 : 3)) begin
                    errors++;
                    $display("FAIL scan: phase=%0d cycle=%0d an=%b seg=%b required an=%b seg=%b", p, c, an, seg,
                             (d == 0) ? 2'b10 : 2'b01, hex_seg((d == 0) ? 10 : 3));
                end
                tick();
            end
            d = 1 - d;
        end
        checks++;
        if (rd !== 8'h3A || out_valid !== 1'b1) begin
            errors++; $display("FAIL display_rd_held: rd=%h ov=%b required rd=3a ov=1", rd, out_valid);
        end
        out_ready = 1'b1;
        tick();
    endtask

    // Display register follows accepted results even while the output is stalled
    task automatic test_display_stalled();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd2; rs = 8'hE7; rt = 8'h00;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 2 * SCAN_DIV + 2; c++) begin
            tick();
            if (c >= 1) begin
                checks++;
                if (!((an === 2'b10 && seg === hex_seg(7)) || (an === 2'b01 && seg === hex_seg(14)))) begin
                    errors++; $display("FAIL disp_e7: an=%b seg=%b required digit pattern of e7", an, seg);
                end
            end
        end
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        init_dut();
        test_reset();
        test_directed_ops();
        test_random_ops();
        test_back_to_back();
        test_backpressure();
        test_display();
        test_display_stalled();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_alu_display.md
PIPELINED_ALU_DISPLAY -- requirements
Module: pipelined_alu_display

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal values 4, 8, 12, 16.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles each display digit is driven; minimum 1.
REQ-003 SHALL derive DIGITS = WIDTH/4 as a localparam, not a port parameter.
REQ-004 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, operation request valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a request this cycle.
REQ-008 SHALL have port op, input, 3, operation select.
REQ-009 SHALL have port rs, input, WIDTH, first operand.
REQ-010 SHALL have port rt, input, WIDTH, second operand.
REQ-011 SHALL have port out_valid, output, 1, result register holds an undelivered result.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port rd, output, WIDTH, registered result.
REQ-014 SHALL have port seg, output, 8, active-low segments {a,b,c,d,e,f,g,dp}, bit 7 = a, bit 0 = dp.
REQ-015 SHALL have port an, output, DIGITS, active-low one-hot digit enable.

Function
REQ-016 op encoding SHALL be: 000 rs-rt, 001 rs+rt, 010 rs|rt, 011 rs&rt, 100 arithmetic right shift of rt by 1 (MSB replicated), 101 rotate-left of rs by 1 (rs MSB into bit 0), 110 less-than, 111 equal.
REQ-017 Add/sub SHALL be modulo 2^WIDTH; carry/borrow discarded.
REQ-018 Ops 110/111 SHALL produce the compare bit in rd[0], all other bits 0.
REQ-019 in_ready SHALL equal (!out_valid || out_ready), combinational.
REQ-020 A request SHALL be accepted when in_valid && in_ready; rd and out_valid=1 are loaded on that edge (latency 1 cycle).
REQ-021 When out_valid && out_ready and no request is accepted, out_valid SHALL clear next edge; rd holds its value.
REQ-022 Simultaneous delivery and acceptance SHALL load the new result with out_valid staying 1; no bubble.
REQ-023 While out_valid && !out_ready, rd and out_valid SHALL stay unchanged and no request SHALL be accepted.
REQ-024 An internal display register SHALL load the new result on every accepted request, independent of out_ready.
REQ-025 A scan counter SHALL count 0..SCAN_DIV-1; on wrap, digit index SHALL advance, DIGITS-1 wrapping to 0.
REQ-026 an[i] SHALL be 0 only for current digit i; seg SHALL show hex nibble disp[4i+3:4i], registered together with an.
REQ-027 Hex patterns SHALL be: 0=00000011 1=10011111 2=00100101 3=00001101 4=10011001 5=01001001 6=01000001 7=00011111 8=00000001 9=00001001 A=00010001 b=11000001 C=01100011 d=10000101 E=01100001 F=01110001.

Reset
REQ-028 On a rising edge with rst_n=0, SHALL set out_valid=0, rd=0, display register=0, scan counter=0, digit index=0, an=all ones, seg=8'hFF.
REQ-029 Reset mid-transaction SHALL discard the pending result; a request presented in the reset cycle SHALL not be accepted.
REQ-030 First edge after release SHALL drive digit 0 showing "0" (an[0]=0, seg=00000011).

Configuration
REQ-031 With PALU_SIGNED_CMP_EN defined, op 110 SHALL compare rs<rt as two's-complement signed; without it, unsigned. Op 111 SHALL be unaffected.

Structure
REQ-032 Package palu_pkg SHALL hold the op encoding typedef and the 16-entry segment pattern constant table.
REQ-033 Sub-module seg_hex_decode (4-bit nibble -> 8-bit seg, combinational) SHALL be the only sub-module.

Verification (WIDTH=8, SCAN_DIV=4)
REQ-034 rst_n=0 two cycles with in_valid=1 -> out_valid=0, rd=0x00, an=2'b11, seg=0xFF; after release an=2'b10, seg=00000011.
REQ-035 op=001 rs=0x7F rt=0x01, out_ready=1 -> next cycle rd=0x80, out_valid=1; op=000 rs=0x03 rt=0x05 -> rd=0xFE; op=100 rt=0x81 -> 0xC0; op=101 rs=0x81 -> 0x03.
REQ-036 out_ready=0 with result 0x80 held, new in_valid -> in_ready=0, rd stays 0x80 for 5 cycles; out_ready=1 with in_valid=1 -> next rd = new result, out_valid stays 1.
REQ-037 Result 0x3A -> an=2'b10, seg=00010001 for 4 cycles, then an=2'b01, seg=00001101 for 4 cycles, repeating.
REQ-038 op=110 rs=0x80 rt=0x01 -> rd=0x00 without PALU_SIGNED_CMP_EN, rd=0x01 with it; op=111 rs=rt=0x5A -> rd=0x01 both builds.
